// File: rtl/acc_cpu_pkg.sv
// rtl/acc_cpu_pkg.sv - shared opcodes, FSM state encoding and ALU op selection for param_acc_cpu
package acc_cpu_pkg;

    localparam int OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_LDA = 4'h0;
    localparam logic [OPC_W-1:0] OP_STA = 4'h1;
    localparam logic [OPC_W-1:0] OP_ADD = 4'h2;
    localparam logic [OPC_W-1:0] OP_SUB = 4'h3;
    localparam logic [OPC_W-1:0] OP_AND = 4'h4;
    localparam logic [OPC_W-1:0] OP_OR  = 4'h5;
    localparam logic [OPC_W-1:0] OP_JMP = 4'h6;
    localparam logic [OPC_W-1:0] OP_JN  = 4'h7;
    localparam logic [OPC_W-1:0] OP_JZ  = 4'h8;
    localparam logic [OPC_W-1:0] OP_JC  = 4'h9;
    localparam logic [OPC_W-1:0] OP_LDI = 4'hA;
    localparam logic [OPC_W-1:0] OP_SHL = 4'hB;
    localparam logic [OPC_W-1:0] OP_SHR = 4'hC;
    localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    // PASS forwards the operand and keeps the carry, which covers LDA and LDI
    typedef enum logic [2:0] {
        ALU_PASS = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_OR   = 3'd4,
        ALU_SHL  = 3'd5,
        ALU_SHR  = 3'd6
    } alu_op_t;

    // Instructions that need a second memory request after decode
    function automatic logic is_mem_op(input logic [OPC_W-1:0] opc);
        return (opc == OP_LDA) || (opc == OP_STA) || (opc == OP_ADD) ||
               (opc == OP_SUB) || (opc == OP_AND) || (opc == OP_OR);
    endfunction

    function automatic alu_op_t alu_op_of(input logic [OPC_W-1:0] opc);
        case (opc)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_SHL:  return ALU_SHL;
            OP_SHR:  return ALU_SHR;
            default: return ALU_PASS;
        endcase
    endfunction

endpackage

// File: rtl/acc_alu.sv
// rtl/acc_alu.sv - combinational accumulator ALU producing {carry_out, result}
module acc_alu
    import acc_cpu_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] acc,
    input  logic [W-1:0] operand,
    input  alu_op_t      op,
    input  logic         carry_in,
    output logic [W-1:0] result,
    output logic         carry_out
);

    logic [W:0] wide;

    // One W+1 bit result; the top bit is the carry/borrow or the shifted-out bit
    always_comb begin
        wide = {carry_in, operand};
        case (op)
            ALU_ADD: wide = {1'b0, acc} + {1'b0, operand};
            ALU_SUB: wide = {1'b0, acc} - {1'b0, operand};
            ALU_AND: wide = {carry_in, acc & operand};
            ALU_OR:  wide = {carry_in, acc | operand};
            ALU_SHL: wide = {acc, 1'b0};
            ALU_SHR: wide = {acc[0], 1'b0, acc[W-1:1]};
            default: wide = {carry_in, operand};
        endcase
    end

    assign result    = wide[W-1:0];
    assign carry_out = wide[W];

endmodule

// File: rtl/param_acc_cpu.sv
// rtl/param_acc_cpu.sv - parametrised single-accumulator CPU with PC, wait states, condition jumps and halt
module param_acc_cpu
    import acc_cpu_pkg::*;
#(
    parameter int                ADDR_W   = 12,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_address,
    output logic              memrq,
    output logic              rnw,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_out
);

    generate
        if (DATA_W != ADDR_W + OPC_W) begin : g_bad_width
            $error("param_acc_cpu: DATA_W must equal ADDR_W+4");
        end
    endgenerate

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] acc;
    logic              carry;

    logic [OPC_W-1:0]  opcode;
    logic [ADDR_W-1:0] opd;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;

    assign opcode = ir[DATA_W-1:ADDR_W];
    assign opd    = ir[ADDR_W-1:0];

    // Memory data feeds the ALU in S_MEM; immediate forms (LDI, shifts) use the zero-extended operand
    assign alu_b = (state == S_MEM) ? in_data : {{OPC_W{1'b0}}, opd};

    acc_alu #(.W(DATA_W)) u_alu (
        .acc       (acc),
        .operand   (alu_b),
        .op        (alu_op_of(opcode)),
        .carry_in  (carry),
        .result    (alu_result),
        .carry_out (alu_carry)
    );

    // Control FSM together with pc, ir, acc and carry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            ir    <= '0;
            acc   <= '0;
            carry <= 1'b0;
        end else begin
            case (state)
                S_IDLE: state <= S_FETCH;
                S_FETCH: begin
                    if (mem_ready) begin
                        ir    <= in_data;
                        pc    <= pc + 1'b1;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    state <= S_FETCH;
                    case (opcode)
                        OP_JMP: pc <= opd;
                        OP_JN:  if (acc[DATA_W-1]) pc <= opd;
                        OP_JZ:  if (acc == '0) pc <= opd;
                        OP_JC:  if (carry) pc <= opd;
                        OP_LDI, OP_SHL, OP_SHR: begin
                            acc   <= alu_result;
                            carry <= alu_carry;
                        end
                        OP_HLT: state <= S_HALT;
                        default: begin
                            if (is_mem_op(opcode)) state <= S_MEM;
                        end
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (opcode != OP_STA) begin
                            acc   <= alu_result;
                            carry <= alu_carry;
                        end
                        state <= S_FETCH;
                    end
                end
                S_HALT: state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Bus outputs depend only on registered state, so they hold steady through wait states
    always_comb begin
        memrq       = 1'b0;
        rnw         = 1'b1;
        out_address = '0;
        case (state)
            S_FETCH: begin
                memrq       = 1'b1;
                out_address = pc;
            end
            S_MEM: begin
                memrq       = 1'b1;
                out_address = opd;
                rnw         = (opcode != OP_STA);
            end
            default: ;
        endcase
    end

    assign out_data = acc;
    assign halted   = (state == S_HALT);
    assign pc_out   = pc;

endmodule
